seg7_mux_capture: RTL

- Receive end of the team's 2-digit multiplexed seven-segment display interface: 7 segment lines plus 2 digit-common strobes.
- Recovers the displayed decimal value (ones, tens, blanked-tens), detects display-off and illegal segment patterns.
- Used as an on-chip loopback monitor and as the decoder in companion/test designs that observe a display bus.
- Oversamples the bus with its own faster clock.

---
 rtl/seg7_mux_capture.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/seg7_mux_capture.sv
// Receive side of a 2-digit multiplexed seven-segment bus: synchronizes the
// pins, qualifies each digit strobe and recovers the displayed decimal value.
module seg7_mux_capture #(
  parameter int STABLE_CYCLES = 3,
  parameter int TIMEOUT       = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg_in,
  input  logic [1:0] com_in,
  input  logic       seg_pol,
  input  logic       com_pol,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic       tens_blank,
  output logic       valid,
  output logic       disp_off,
  output logic       update,
  output logic       pattern_err
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [3:0]    STABLE_N = 4'(STABLE_CYCLES);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_QUAL = 2'd1;
  localparam logic [1:0] S_HELD = 2'd2;

  // Returns {legal, digit}; alternate glyphs for 6, 7 and 9 are accepted.
  function automatic logic [4:0] seg_decode(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'h3F:         r = {1'b1, 4'd0};
      7'h06:         r = {1'b1, 4'd1};
      7'h5B:         r = {1'b1, 4'd2};
      7'h4F:         r = {1'b1, 4'd3};
      7'h66:         r = {1'b1, 4'd4};
      7'h6D:         r = {1'b1, 4'd5};
      7'h7D, 7'h7C:  r = {1'b1, 4'd6};
      7'h07, 7'h27:  r = {1'b1, 4'd7};
      7'h7F:         r = {1'b1, 4'd8};
      7'h6F, 7'h67:  r = {1'b1, 4'd9};
      default:       r = 5'd0;
    endcase
    return r;
  endfunction

  logic [6:0] seg_s1_q, seg_s2_q;
  logic [1:0] com_s1_q, com_s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1_q <= '0;
      seg_s2_q <= '0;
      com_s1_q <= '0;
      com_s2_q <= '0;
    end else begin
      seg_s1_q <= seg_in;
      seg_s2_q <= seg_s1_q;
      com_s1_q <= com_in;
      com_s2_q <= com_s1_q;
    end
  end

  // ---- synchronized, polarity-normalized bus ----
  logic [6:0] seg;
  logic [1:0] com;
  logic [1:0] excl;
  logic [1:0] cap;

  assign seg  = seg_pol ? seg_s2_q : ~seg_s2_q;
  assign com  = com_pol ? com_s2_q : ~com_s2_q;
  assign excl = {com[1] & ~com[0], com[0] & ~com[1]};

  for (genvar g = 0; g < 2; g++) begin : g_dig
    logic [1:0] st_q, st_d;
    logic [3:0] cnt_q, cnt_d;
    logic [6:0] ref_q, ref_d;
    logic       cap_c;

    always_comb begin
      st_d  = st_q;
      cnt_d = cnt_q;
      ref_d = ref_q;
      cap_c = 1'b0;
      case (st_q)
        S_IDLE: begin
          if (excl[g]) begin
            ref_d = seg;
            cnt_d = 4'd1;
            if (STABLE_N == 4'd1) begin
              cap_c = 1'b1;
              st_d  = S_HELD;
            end else begin
              st_d  = S_QUAL;
            end
          end
        end
        S_QUAL: begin
          if (!excl[g]) begin
            st_d  = S_IDLE;
            cnt_d = '0;
          end else if (seg != ref_q) begin
            ref_d = seg;
            cnt_d = 4'd1;
          end else if (cnt_q + 4'd1 == STABLE_N) begin
            cap_c = 1'b1;
            st_d  = S_HELD;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        // One capture per strobe: wait for the own common to release.
        S_HELD: begin
          if (!com[g]) st_d = S_IDLE;
        end
        default: st_d = S_IDLE;
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st_q  <= S_IDLE;
        cnt_q <= '0;
        ref_q <= '0;
      end else begin
        st_q  <= st_d;
        cnt_q <= cnt_d;
        ref_q <= ref_d;
      end
    end

    assign cap[g] = cap_c;
  end

  // ---- capture registers, blanking, timeout ----
  logic [4:0]    dec;
  logic [3:0]    ones_q, ones_d, tens_q, tens_d;
  logic          blank_q, blank_d, valid_q, valid_d;
  logic          off_q, off_d, upd_q, upd_d, perr_q, perr_d;
  logic          ost_q, ost_d;
  logic [TW-1:0] tmo_q, tmo_d;

  assign dec = seg_decode(seg);

  always_comb begin
    ones_d  = ones_q;
    tens_d  = tens_q;
    blank_d = blank_q;
    valid_d = valid_q;
    off_d   = off_q;
    ost_d   = ost_q;
    tmo_d   = tmo_q;
    perr_d  = 1'b0;
    if (cap[1]) begin
      ost_d = 1'b0;
      if (dec[4]) begin
        tens_d  = dec[3:0];
        blank_d = 1'b0;
      end else begin
        perr_d = 1'b1;
      end
    end
    // ost_q marks a ones capture with no tens capture since.
    if (cap[0]) begin
      if (ost_q) begin
        blank_d = 1'b1;
        tens_d  = 4'd0;
      end
      ost_d = 1'b1;
      tmo_d = '0;
      off_d = 1'b0;
      if (dec[4]) begin
        ones_d  = dec[3:0];
        valid_d = 1'b1;
      end else begin
        perr_d = 1'b1;
      end
    end else begin
      if (tmo_q != TMO_MAX) tmo_d = tmo_q + TW'(1);
      if (tmo_d == TMO_MAX) begin
        off_d   = 1'b1;
        valid_d = 1'b0;
      end
    end
    upd_d = ({blank_d, tens_d, ones_d} != {blank_q, tens_q, ones_q});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones_q  <= '0;
      tens_q  <= '0;
      blank_q <= 1'b1;
      valid_q <= 1'b0;
      off_q   <= 1'b1;
      upd_q   <= 1'b0;
      perr_q  <= 1'b0;
      ost_q   <= 1'b0;
      tmo_q   <= '0;
    end else begin
      ones_q  <= ones_d;
      tens_q  <= tens_d;
      blank_q <= blank_d;
      valid_q <= valid_d;
      off_q   <= off_d;
      upd_q   <= upd_d;
      perr_q  <= perr_d;
      ost_q   <= ost_d;
      tmo_q   <= tmo_d;
    end
  end

  assign ones        = ones_q;
  assign tens        = tens_q;
  assign tens_blank  = blank_q;
  assign valid       = valid_q;
  assign disp_off    = off_q;
  assign update      = upd_q;
  assign pattern_err = perr_q;

endmodule
